and_gate_core: RTL and testbench



---
 rtl/and_gate_pkg.sv | 16 +
 rtl/and_gate_if.sv | 48 ++++
 rtl/and_gate_out_reg.sv | 43 ++++
 rtl/and_gate_core.sv | 36 +++
 tb/tb_and_gate_core.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/and_gate_pkg.sv
// Shared constants for the and_gate_core slice.
// Optional feature macro: AND_GATE_HIT_COUNT_EN (adds the saturating hit counter).
package and_gate_pkg;

    localparam int unsigned DEFAULT_WIDTH = 1;
    localparam int unsigned MAX_WIDTH     = 64;
    localparam int unsigned HIT_CNT_W     = 16;

    localparam logic [HIT_CNT_W-1:0] HIT_CNT_MAX = 16'hFFFF;

    // Next hit count value, holding at the maximum instead of wrapping.
    function automatic logic [HIT_CNT_W-1:0] hit_cnt_next(input logic [HIT_CNT_W-1:0] cnt);
        return (cnt == HIT_CNT_MAX) ? cnt : cnt + HIT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/and_gate_if.sv
// Operand/result bundle for and_gate_core.
// Optional feature macro: AND_GATE_HIT_COUNT_EN (adds hit_cnt).
interface and_gate_if
    import and_gate_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 in_valid;
    logic [WIDTH-1:0]     y;
    logic [WIDTH-1:0]     y_q;
    logic                 y_valid;
    logic                 all_ones;
`ifdef AND_GATE_HIT_COUNT_EN
    logic [HIT_CNT_W-1:0] hit_cnt;
`endif

    // Producer side: drives operands, observes results.
    modport master (
        output a,
        output b,
        output in_valid,
        input  y,
        input  y_q,
        input  y_valid,
        input  all_ones
`ifdef AND_GATE_HIT_COUNT_EN
       ,input  hit_cnt
`endif
    );

    // Gate side: consumes operands, produces results.
    modport slave (
        input  a,
        input  b,
        input  in_valid,
        output y,
        output y_q,
        output y_valid,
        output all_ones
`ifdef AND_GATE_HIT_COUNT_EN
       ,output hit_cnt
`endif
    );

endinterface

// File: rtl/and_gate_out_reg.sv
// Registered result stage: one-cycle copy of the AND result plus valid flag.
// Optional feature macro: AND_GATE_HIT_COUNT_EN (saturating count of all-ones captures).
module and_gate_out_reg
    import and_gate_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     d,
    output logic [WIDTH-1:0]     y_q,
    output logic                 y_valid
`ifdef AND_GATE_HIT_COUNT_EN
   ,output logic [HIT_CNT_W-1:0] hit_cnt
`endif
);

    // Capture on in_valid, hold data otherwise; reset wins over a same-edge capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= in_valid;
            if (in_valid) begin
                y_q <= d;
            end
        end
    end

`ifdef AND_GATE_HIT_COUNT_EN
    // Count captures whose result is all ones, saturating at the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt <= '0;
        end else if (in_valid && (&d)) begin
            hit_cnt <= hit_cnt_next(hit_cnt);
        end
    end
`endif

endmodule

// File: rtl/and_gate_core.sv
// Bitwise 2-input AND with combinational and registered result.
// Optional feature macro: AND_GATE_HIT_COUNT_EN (exposes hit_cnt on the interface).
module and_gate_core
    import and_gate_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    and_gate_if.slave   bus
);

    logic [WIDTH-1:0] y_int;

    // Zero-latency AND and its reduction; X/Z pass through untouched.
    always_comb begin
        y_int        = bus.a & bus.b;
        bus.y        = y_int;
        bus.all_ones = &y_int;
    end

    and_gate_out_reg #(
        .WIDTH    (WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.in_valid),
        .d        (y_int),
        .y_q      (bus.y_q),
        .y_valid  (bus.y_valid)
`ifdef AND_GATE_HIT_COUNT_EN
       ,.hit_cnt  (bus.hit_cnt)
`endif
    );

endmodule

// File: tb/tb_and_gate_core.sv
// Directed self-checking bench for and_gate_core at WIDTH=1 and WIDTH=4.
// Optional feature macro: AND_GATE_HIT_COUNT_EN (counter checks included when defined).
module tb_and_gate_core;

    logic clk;
    logic rst;

    int unsigned n_checks;
    int unsigned n_errors;

    and_gate_if #(.WIDTH(1)) bus1 ();
    and_gate_if #(.WIDTH(4)) bus4 ();

    and_gate_core #(.WIDTH(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    and_gate_core #(.WIDTH(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive1(input logic a, input logic b, input logic v);
        bus1.a        = a;
        bus1.b        = b;
        bus1.in_valid = v;
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic v);
        bus4.a        = a;
        bus4.b        = b;
        bus4.in_valid = v;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] sweep_ab [4];
    logic       sweep_y  [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drive1(1'b0, 1'b0, 1'b0);
        drive4(4'h0, 4'h0, 1'b0);
        tick();
        tick();

        check("rst_y_q1",     64'(bus1.y_q),     64'h0);
        check("rst_y_valid1", 64'(bus1.y_valid), 64'h0);
        check("rst_y_q4",     64'(bus4.y_q),     64'h0);
        check("rst_y_valid4", 64'(bus4.y_valid), 64'h0);

        // Exhaustive truth table under reset, 10 ns per step.
        sweep_ab[0] = 2'b00; sweep_y[0] = 1'b0;
        sweep_ab[1] = 2'b01; sweep_y[1] = 1'b0;
        sweep_ab[2] = 2'b10; sweep_y[2] = 1'b0;
        sweep_ab[3] = 2'b11; sweep_y[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive1(sweep_ab[i][1], sweep_ab[i][0], 1'b0);
            #1;
            check($sformatf("sweep_y_%0d", i),        64'(bus1.y),        64'(sweep_y[i]));
            check($sformatf("sweep_all_ones_%0d", i), 64'(bus1.all_ones), 64'(sweep_y[i]));
            #9;
        end

        // Reset priority over a same-edge capture.
        @(negedge clk);
        drive1(1'b1, 1'b1, 1'b1);
        drive4(4'hF, 4'hF, 1'b1);
        #1;
        check("prio_y_pre", 64'(bus1.y), 64'h1);
        tick();
        check("prio_y_q1",     64'(bus1.y_q),     64'h0);
        check("prio_y_valid1", 64'(bus1.y_valid), 64'h0);
        check("prio_y_q4",     64'(bus4.y_q),     64'h0);
        check("prio_y_post",   64'(bus1.y),       64'h1);

        // First edge after reset release captures normally.
        @(negedge clk);
        rst = 1'b0;
        drive1(1'b1, 1'b1, 1'b1);
        drive4(4'hC, 4'hA, 1'b1);
        #1;
        check("w4_y_c_a",        64'(bus4.y),        64'h8);
        check("w4_all_ones_c_a", 64'(bus4.all_ones), 64'h0);
        tick();
        check("cap_y_q1",     64'(bus1.y_q),     64'h1);
        check("cap_y_valid1", 64'(bus1.y_valid), 64'h1);
        check("cap_y_q4",     64'(bus4.y_q),     64'h8);

        // in_valid low: data held, valid drops.
        @(negedge clk);
        drive1(1'b0, 1'b1, 1'b0);
        drive4(4'hF, 4'hF, 1'b1);
        #1;
        check("w4_y_ff",        64'(bus4.y),        64'hF);
        check("w4_all_ones_ff", 64'(bus4.all_ones), 64'h1);
        check("idle_y1",        64'(bus1.y),        64'h0);
        tick();
        check("idle_y_valid1", 64'(bus1.y_valid), 64'h0);
        check("idle_y_q1",     64'(bus1.y_q),     64'h1);
        check("w4_y_q_ff",     64'(bus4.y_q),     64'hF);
        check("w4_valid_ff",   64'(bus4.y_valid), 64'h1);

        @(negedge clk);
        drive4(4'h3, 4'h5, 1'b0);
        #1;
        check("w4_y_35", 64'(bus4.y), 64'h1);
        tick();
        check("w4_hold_y_q",   64'(bus4.y_q),     64'hF);
        check("w4_hold_valid", 64'(bus4.y_valid), 64'h0);

        // Mid-stream reset clears registers despite a capture request.
        @(negedge clk);
        rst = 1'b1;
        drive4(4'h6, 4'h7, 1'b1);
        tick();
        check("mid_rst_y_q4",   64'(bus4.y_q),     64'h0);
        check("mid_rst_valid4", 64'(bus4.y_valid), 64'h0);
        check("mid_rst_y4",     64'(bus4.y),       64'h6);

        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_y_q4",   64'(bus4.y_q),     64'h6);
        check("post_rst_valid4", 64'(bus4.y_valid), 64'h1);

`ifdef AND_GATE_HIT_COUNT_EN
        @(negedge clk);
        rst = 1'b1;
        drive1(1'b0, 1'b0, 1'b0);
        drive4(4'h0, 4'h0, 1'b0);
        tick();
        check("cnt_rst1", 64'(bus1.hit_cnt), 64'h0);

        // Three all-ones captures, two non-hits, one uncaptured all-ones.
        @(negedge clk);
        rst = 1'b0;
        drive1(1'b1, 1'b1, 1'b1);
        drive4(4'hF, 4'hF, 1'b1);
        repeat (3) tick();
        @(negedge clk);
        drive1(1'b1, 1'b0, 1'b1);
        drive4(4'hF, 4'hE, 1'b1);
        repeat (2) tick();
        @(negedge clk);
        drive1(1'b1, 1'b1, 1'b0);
        drive4(4'hF, 4'hF, 1'b0);
        tick();
        check("cnt_three1", 64'(bus1.hit_cnt), 64'h3);
        check("cnt_three4", 64'(bus4.hit_cnt), 64'h3);

        // Run up to one below max, then two more hits must saturate.
        @(negedge clk);
        drive1(1'b1, 1'b1, 1'b1);
        repeat (65531) @(posedge clk);
        #1;
        check("cnt_near_max", 64'(bus1.hit_cnt), 64'hFFFE);
        repeat (2) tick();
        check("cnt_sat", 64'(bus1.hit_cnt), 64'hFFFF);
        tick();
        check("cnt_sat_hold", 64'(bus1.hit_cnt), 64'hFFFF);

        @(negedge clk);
        rst = 1'b1;
        tick();
        check("cnt_clear", 64'(bus1.hit_cnt), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        drive1(1'b0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
